uart_cmd_rx: RTL
================

# uart_cmd_rx

Host-to-FPGA command receiver for the camera/colour-recognition pipeline. It deserialises 8N1 UART bytes from the host on `i_Rx`, the return path of the existing colour-report transmitter. It parses 4-byte command packets and issues single-cycle strobes. The top-level capture FSM uses `o_Frame_Request` in place of the external frame-indicator pin. Decoded command/argument pairs are exposed for future control registers.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: clocks per UART bit (100 MHz / 9600 baud); minimum 8.
- `TIMEOUT_CLKS`, default 208320: idle clocks allowed between bytes of one packet (about 20 bit times).

Ports:
- `Clk`, input, 1: single system clock; all logic on posedge.
- `i_Rst_n`, input, 1: reset, asynchronous, active-low.
- `i_Rx`, input, 1: asynchronous UART line, idle high.
- `o_Byte`, output, 8: last received byte.
- `o_Byte_Valid`, output, 1: 1-cycle strobe, `o_Byte` updated.
- `o_Cmd`, output, 8: command of last good packet.
- `o_Arg`, output, 8: argument of last good packet.
- `o_Cmd_Valid`, output, 1: 1-cycle strobe, good packet decoded.
- `o_Frame_Request`, output, 1: 1-cycle strobe, good packet with CMD=0x01.
- `o_Err`, output, 1: 1-cycle strobe for framing, checksum, or timeout error.
- `o_Err_Count`, output, 8: saturating error count.

## Operation
- Packet format: SYNC=0xA5, CMD, ARG, CHK, with CHK = CMD ^ ARG ^ 0xA5. Bytes are LSB first, 1 stop bit, no parity.
- `i_Rx` passes through a 2-flop synchroniser. It resets to 1.
- **Bit FSM**
  - IDLE → START on a synchronised high-to-low transition.
  - START: after CLKS_PER_BIT/2 clocks, sample the line. If it is high, treat as a false start and return to IDLE silently. Otherwise go to DATA.
  - DATA: take 8 samples spaced CLKS_PER_BIT apart, shifting in LSB first.
  - STOP: sample after CLKS_PER_BIT. If the sample is 1, latch `o_Byte` and pulse `o_Byte_Valid`, then go to IDLE. If it is 0, raise a framing error and go to BREAK.
  - BREAK: wait for the line to be high, then go to IDLE.
- **Packet FSM**
  - P_SYNC: bytes other than 0xA5 are discarded without error.
  - P_CMD and P_ARG store CMD and ARG.
  - P_CHK compares the received byte with the computed checksum. On a match, load `o_Cmd`/`o_Arg` and pulse `o_Cmd_Valid`; also pulse `o_Frame_Request` if CMD=0x01. On a mismatch, raise a checksum error. Both cases return to P_SYNC.
- **Timeout:** a counter runs while the packet FSM is not in P_SYNC and clears on each `o_Byte_Valid`. On reaching TIMEOUT_CLKS it raises a timeout error and returns the FSM to P_SYNC.
- A framing error in any packet state also returns the FSM to P_SYNC.
- **Error reporting:** each error pulses `o_Err` once and increments `o_Err_Count`, which saturates at 0xFF. Simultaneous error sources in one cycle count as one error.
- **Reset values:** all outputs 0, bit FSM IDLE, packet FSM P_SYNC, counters 0. A reset mid-byte or mid-packet discards partial data, and no strobe is issued.

## Timing
- `o_Byte_Valid` is asserted in the cycle after the stop-bit sample.
- That sample occurs (9.5 × CLKS_PER_BIT) + 2 synchroniser cycles, ±1, after the start edge.
- `o_Cmd_Valid`, `o_Frame_Request` and the checksum `o_Err` are asserted 1 cycle after the CHK byte's `o_Byte_Valid`.
- `o_Cmd`/`o_Arg` change in that same cycle and hold until the next good packet.
- Back-to-back bytes, with the next start edge immediately after the stop sample, are received without loss.
- Strobes are never longer than 1 cycle. `o_Frame_Request` and `o_Cmd_Valid` are coincident.

## Structure
- Shared package/header holds SYNC_BYTE=8'hA5, CMD_FRAME_REQ=8'h01, the bit-FSM state encodings, the packet-FSM state encodings, and the default CLKS_PER_BIT.
- Sub-module `uart_rx_byte` covers the synchroniser, the bit FSM, and the framing-error output.
- The parent contains the packet FSM, the timeout counter, and error counting.

## Test plan
Directed scenarios, all with CLKS_PER_BIT=16 and TIMEOUT_CLKS=400:
- **Good packet:** A5 01 00 A4 → one `o_Frame_Request` and one `o_Cmd_Valid`; `o_Cmd`=0x01, `o_Arg`=0x00; `o_Err_Count`=0.
- **Checksum error:** A5 07 3C 00 → `o_Err` pulse, no `o_Cmd_Valid`, `o_Err_Count`=1. A following A5 07 3C 9E → `o_Cmd`=0x07, `o_Arg`=0x3C, and no `o_Frame_Request`.
- **Glitch and junk bytes:** a 4-cycle low glitch on `i_Rx` → no `o_Byte_Valid`. Junk 0x12 0x34 before a good packet → decoded normally, no error.
- **Framing error:** stop bit driven 0 during the ARG byte → `o_Err`; the line is held low 50 cycles, then released. A new full packet → decoded.
- **Timeout:** A5 01, then 500 idle cycles → exactly one `o_Err`. Then 00 A4 alone → no strobe.
- **Reset and saturation:** `i_Rst_n` asserted mid-DATA → all outputs 0 immediately; a packet after release decodes. 300 bad packets → `o_Err_Count`=0xFF.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// rtl/uart_cmd_rx_pkg.sv - shared constants, state encodings and checksum helper for uart_cmd_rx
//
// Purpose : packet constants, bit-FSM and packet-FSM encodings, and the default UART bit period.
// Ports   : none (package)

package uart_cmd_rx_pkg;

    localparam logic [7:0] SYNC_BYTE            = 8'hA5;
    localparam logic [7:0] CMD_FRAME_REQ        = 8'h01;
    localparam int         DEFAULT_CLKS_PER_BIT = 10416;

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_BREAK
    } bit_state_e;

    typedef enum logic [1:0] {
        P_SYNC,
        P_CMD,
        P_ARG,
        P_CHK
    } pkt_state_e;

    // CHK byte expected for a given CMD/ARG pair.
    function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] arg);
        return cmd ^ arg ^ SYNC_BYTE;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser and framing-error strobe
//
// Purpose : synchronises the raw line, runs the bit FSM and emits one byte per good frame.
// Ports   : Clk           - system clock
//           i_Rst_n       - asynchronous active-low reset
//           i_Rx          - asynchronous UART line, idle high
//           o_Byte        - last received byte
//           o_Byte_Valid  - 1-cycle strobe, o_Byte updated
//           o_Frame_Err   - 1-cycle strobe, stop bit sampled low

module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       Clk,
    input  logic       i_Rst_n,
    input  logic       i_Rx,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic       o_Frame_Err
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    bit_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= B_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            o_Byte       <= '0;
            o_Byte_Valid <= 1'b0;
            o_Frame_Err  <= 1'b0;
        end else begin
            rx_meta_q    <= i_Rx;
            rx_sync_q    <= rx_meta_q;
            o_Byte_Valid <= 1'b0;
            o_Frame_Err  <= 1'b0;

            case (state_q)
                // Every path into IDLE leaves the line known high (reset value,
                // good stop bit, false start, end of break), so a low level seen
                // here is always a fresh high-to-low transition. Using the level
                // also catches a start edge that lands right on the stop sample.
                B_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= B_START;
                    end
                end

                B_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? B_IDLE : B_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                B_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= B_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                B_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            o_Byte       <= shift_q;
                            o_Byte_Valid <= 1'b1;
                            state_q      <= B_IDLE;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state_q     <= B_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                B_BREAK: begin
                    cnt_q <= '0;
                    if (rx_sync_q) begin
                        state_q <= B_IDLE;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= B_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - host command receiver: 4-byte packet parser with timeout and error counting
//
// Purpose : decodes SYNC/CMD/ARG/CHK packets from the UART byte stream into command strobes.
// Ports   : Clk             - system clock
//           i_Rst_n         - asynchronous active-low reset
//           i_Rx            - asynchronous UART line, idle high
//           o_Byte          - last received byte
//           o_Byte_Valid    - 1-cycle strobe, o_Byte updated
//           o_Cmd / o_Arg   - command and argument of the last good packet
//           o_Cmd_Valid     - 1-cycle strobe, good packet decoded
//           o_Frame_Request - 1-cycle strobe, good packet with CMD_FRAME_REQ
//           o_Err           - 1-cycle strobe, framing / checksum / timeout error
//           o_Err_Count     - saturating error count

module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = 208320
) (
    input  logic       Clk,
    input  logic       i_Rst_n,
    input  logic       i_Rx,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Arg,
    output logic       o_Cmd_Valid,
    output logic       o_Frame_Request,
    output logic       o_Err,
    output logic [7:0] o_Err_Count
);

    localparam int            TW     = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CLKS - 1);

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          frame_err;

    pkt_state_e    pkt_q;
    logic [7:0]    cmd_q;
    logic [7:0]    arg_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    err_cnt_q;
    logic [7:0]    err_cnt_d;

    logic          tmo_hit;
    logic          chk_bad;
    logic          err_any;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .Clk          (Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Rx         (i_Rx),
        .o_Byte       (byte_data),
        .o_Byte_Valid (byte_valid),
        .o_Frame_Err  (frame_err)
    );

    assign o_Byte       = byte_data;
    assign o_Byte_Valid = byte_valid;
    assign o_Err_Count  = err_cnt_q;

    // A byte arriving on the last allowed cycle wins over the timeout.
    assign tmo_hit = (pkt_q != P_SYNC) && !byte_valid && (tmo_cnt_q == TMO_M1);
    assign chk_bad = byte_valid && (pkt_q == P_CHK) && (byte_data != calc_chk(cmd_q, arg_q));
    // Coincident sources collapse into a single error event.
    assign err_any = frame_err | chk_bad | tmo_hit;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_any && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pkt_q           <= P_SYNC;
            cmd_q           <= '0;
            arg_q           <= '0;
            tmo_cnt_q       <= '0;
            err_cnt_q       <= '0;
            o_Cmd           <= '0;
            o_Arg           <= '0;
            o_Cmd_Valid     <= 1'b0;
            o_Frame_Request <= 1'b0;
            o_Err           <= 1'b0;
        end else begin
            o_Cmd_Valid     <= 1'b0;
            o_Frame_Request <= 1'b0;
            o_Err           <= err_any;
            err_cnt_q       <= err_cnt_d;

            if ((pkt_q == P_SYNC) || byte_valid) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end

            if (frame_err || tmo_hit) begin
                pkt_q     <= P_SYNC;
                tmo_cnt_q <= '0;
            end else if (byte_valid) begin
                case (pkt_q)
                    P_SYNC: begin
                        if (byte_data == SYNC_BYTE) begin
                            pkt_q <= P_CMD;
                        end
                    end
                    P_CMD: begin
                        cmd_q <= byte_data;
                        pkt_q <= P_ARG;
                    end
                    P_ARG: begin
                        arg_q <= byte_data;
                        pkt_q <= P_CHK;
                    end
                    P_CHK: begin
                        if (!chk_bad) begin
                            o_Cmd           <= cmd_q;
                            o_Arg           <= arg_q;
                            o_Cmd_Valid     <= 1'b1;
                            o_Frame_Request <= (cmd_q == CMD_FRAME_REQ);
                        end
                        pkt_q <= P_SYNC;
                    end
                endcase
            end
        end
    end

endmodule
